// File: rtl/phase_table_sequencer_pkg.sv
// scheduler_pkg: shared FSM encodings and default geometry for the phase table sequencer
package scheduler_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    typedef enum logic {W_FILL, W_PENDING} wr_state_t;
    typedef enum logic {R_IDLE, R_PLAY} rd_state_t;
endpackage

// File: rtl/phase_table_sequencer_if.sv
// phase_table_sequencer_if: decoder-side load port and datapath-side playback port
interface phase_table_sequencer_if
    import scheduler_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] phase;
    logic              writeEn;
    logic              commit;
    logic              play_en;
    logic              step;
    logic [DATA_W-1:0] phase_out;
    logic              phase_valid;
    logic              active_bank;
    logic [ADDR_W:0]   active_len;
    logic              swap_pending;
    logic              wr_drop;
    modport master (
        output phase, writeEn, commit, play_en, step,
        input  phase_out, phase_valid, active_bank, active_len, swap_pending, wr_drop
    );
    modport slave (
        input  phase, writeEn, commit, play_en, step,
        output phase_out, phase_valid, active_bank, active_len, swap_pending, wr_drop
    );
endinterface

// File: rtl/phase_table_sequencer_ram.sv
// phase_table_ram: simple dual-port RAM holding both table banks, address MSB selects the bank
module phase_table_ram #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    // one write and one registered read per cycle
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/phase_table_sequencer.sv
// phase_table_sequencer: ping-pong phase table, shadow fill/commit with atomic swap at a table boundary
module phase_table_sequencer
    import scheduler_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic clk,
    input  logic reset,
    phase_table_sequencer_if.slave bus
);
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] L_DEPTH = PW'(1 << ADDR_W);
    wr_state_t         r_wr_state, w_wr_state_nxt;
    rd_state_t         r_rd_state, w_rd_state_nxt;
    logic [PW-1:0]     r_wr_ptr, r_shadow_len, r_active_len, w_commit_len;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_active_bank, r_wr_drop, r_fire_d1, r_phase_valid;
    logic [DATA_W-1:0] r_phase_out, w_rd_data;
    logic              w_wr_ok, w_commit_ok, w_rd_fire, w_rd_last, w_swap;
    // write/read FSM next state plus the qualified strobes that drive them
    always_comb begin
        w_wr_ok        = bus.writeEn && r_wr_state == W_FILL && r_wr_ptr != L_DEPTH;
        w_commit_len   = r_wr_ptr + {{ADDR_W{1'b0}}, w_wr_ok};
        w_commit_ok    = bus.commit && r_wr_state == W_FILL && w_commit_len != '0;
        w_rd_fire      = bus.step && r_rd_state == R_PLAY;
        w_rd_last      = {1'b0, r_rd_ptr} == PW'(r_active_len - 1);
        w_swap         = r_wr_state == W_PENDING && (r_rd_state == R_IDLE || (w_rd_fire && w_rd_last));
        w_wr_state_nxt = w_swap ? W_FILL : (w_commit_ok ? W_PENDING : r_wr_state);
        w_rd_state_nxt = (bus.play_en && r_active_len != '0) ? R_PLAY : R_IDLE;
    end
    // FSM state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state <= W_FILL;
            r_rd_state <= R_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
        end
    end
    // pointers, lengths and bank select; a swap overrides normal pointer motion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_shadow_len  <= '0;
            r_active_len  <= '0;
            r_rd_ptr      <= '0;
            r_active_bank <= 1'b0;
            r_wr_drop     <= 1'b0;
        end else begin
            if (bus.writeEn && !w_wr_ok) r_wr_drop <= 1'b1;
            if (w_commit_ok) r_shadow_len <= w_commit_len;
            if (w_swap) begin
                r_active_bank <= ~r_active_bank;
                r_active_len  <= r_shadow_len;
                r_rd_ptr      <= '0;
                r_wr_ptr      <= '0;
            end else begin
                if (w_wr_ok) r_wr_ptr <= PW'(r_wr_ptr + 1);
                r_rd_ptr <= (r_rd_state == R_IDLE) ? '0 :
                            !w_rd_fire ? r_rd_ptr :
                            w_rd_last ? '0 : ADDR_W'(r_rd_ptr + 1);
            end
        end
    end
    // output stage: strobe follows the RAM read by one cycle, phase_out holds between strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fire_d1     <= 1'b0;
            r_phase_valid <= 1'b0;
            r_phase_out   <= '0;
        end else begin
            r_fire_d1     <= w_rd_fire;
            r_phase_valid <= r_fire_d1;
            if (r_fire_d1) r_phase_out <= w_rd_data;
        end
    end
    phase_table_ram #(.AW(PW), .DW(DATA_W)) u_ram (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr ({~r_active_bank, r_wr_ptr[ADDR_W-1:0]}),
        .i_wdata (bus.phase),
        .i_raddr ({r_active_bank, r_rd_ptr}),
        .o_rdata (w_rd_data)
    );
    assign bus.phase_out    = r_phase_out;
    assign bus.phase_valid  = r_phase_valid;
    assign bus.active_bank  = r_active_bank;
    assign bus.active_len   = r_active_len;
    assign bus.swap_pending = r_wr_state == W_PENDING;
    assign bus.wr_drop      = r_wr_drop;
endmodule

// File: tb/tb_phase_table_sequencer.sv
// tb_phase_table_sequencer: directed scenarios plus random traffic against a table-level reference model
module tb_phase_table_sequencer;
    localparam int AW = 2;
    localparam int DEPTH = 1 << AW;
    typedef struct {
        int          due;
        logic [31:0] v;
    } strobe_t;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    logic [31:0] m_mem [2][DEPTH];
    bit          m_filling, m_bank, m_playing, m_drop, m_valid;
    int          m_wr_cnt, m_shadow_len, m_act_len, m_rd_idx;
    logic [31:0] m_out;
    strobe_t     m_q[$];
    logic [31:0] seen[$];
    logic [31:0] want[$];
    phase_table_sequencer_if #(.ADDR_W(AW), .DATA_W(32)) bus ();
    phase_table_sequencer #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic m_reset();
        m_filling = 1; m_bank = 0; m_playing = 0; m_drop = 0;
        m_wr_cnt = 0; m_shadow_len = 0; m_act_len = 0; m_rd_idx = 0;
        m_out = 0; m_valid = 0;
        m_q.delete();
    endtask
    task automatic cycle();
        bit wr_ok, fire, last, swap, cok, nxt_play;
        int clen;
        @(posedge clk);
        edge_n++;
        if (reset) m_reset();
        else begin
            wr_ok = bus.writeEn && m_filling && m_wr_cnt < DEPTH;
            if (bus.writeEn && !wr_ok) m_drop = 1;
            fire = bus.step && m_playing;
            last = fire && m_rd_idx == m_act_len - 1;
            swap = !m_filling && (!m_playing || last);
            clen = m_wr_cnt + int'(wr_ok);
            cok = bus.commit && m_filling && clen > 0;
            nxt_play = bus.play_en && m_act_len != 0;
            if (fire) m_q.push_back('{due: edge_n + 1, v: m_mem[m_bank][m_rd_idx]});
            if (wr_ok) begin
                m_mem[m_bank ^ 1'b1][m_wr_cnt] = bus.phase;
                m_wr_cnt++;
            end
            if (cok) begin
                m_shadow_len = clen;
                m_filling = 0;
            end
            m_rd_idx = !m_playing ? 0 : !fire ? m_rd_idx : last ? 0 : m_rd_idx + 1;
            if (swap) begin
                m_bank ^= 1'b1;
                m_act_len = m_shadow_len;
                m_rd_idx = 0;
                m_wr_cnt = 0;
                m_filling = 1;
            end
            m_playing = nxt_play;
            m_valid = 0;
            if (m_q.size() > 0 && m_q[0].due == edge_n) begin
                m_valid = 1;
                m_out = m_q.pop_front().v;
            end
        end
        #1;
        chk("phase_valid", bus.phase_valid, m_valid);
        chk("phase_out", bus.phase_out, m_out);
        chk("active_bank", bus.active_bank, m_bank);
        chk("active_len", bus.active_len, m_act_len);
        chk("swap_pending", bus.swap_pending, !m_filling);
        chk("wr_drop", bus.wr_drop, m_drop);
        if (bus.phase_valid === 1'b1) seen.push_back(bus.phase_out);
    endtask
    task automatic idle(input int n);
        repeat (n) cycle();
    endtask
    task automatic wr(input logic [31:0] v);
        bus.writeEn = 1; bus.phase = v;
        cycle();
        bus.writeEn = 0;
    endtask
    task automatic steps(input int n);
        bus.step = 1;
        repeat (n) cycle();
        bus.step = 0;
    endtask
    task automatic chk_seen(input string tag);
        chk({tag, "_count"}, seen.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            if (i < seen.size()) chk(tag, seen[i], want[i]);
        seen.delete();
    endtask
    initial begin
        reset = 1;
        bus.phase = 0; bus.writeEn = 0; bus.commit = 0; bus.play_en = 0; bus.step = 0;
        idle(2);
        reset = 0;
        chk("rst_len", bus.active_len, 0);
        chk("rst_valid", bus.phase_valid, 0);
        chk("rst_out", bus.phase_out, 0);
        // load and play
        for (int i = 0; i < 4; i++) wr(32'h10 + i);
        bus.commit = 1; cycle(); bus.commit = 0;
        chk("t1_pending", bus.swap_pending, 1);
        bus.play_en = 1;
        idle(3);
        chk("t1_len", bus.active_len, 4);
        steps(6);
        idle(3);
        want = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h10, 32'h11};
        chk_seen("t1_seq");
        // boundary swap
        bus.play_en = 0; idle(2);
        wr(1); wr(2); wr(3);
        bus.commit = 1; cycle(); bus.commit = 0;
        idle(2);
        chk("t2_lenA", bus.active_len, 3);
        bus.play_en = 1; idle(2);
        steps(1);
        wr(7); wr(8);
        bus.commit = 1; cycle(); bus.commit = 0;
        chk("t2_pending", bus.swap_pending, 1);
        bus.step = 1;
        cycle();
        chk("t2_pend_mid", bus.swap_pending, 1);
        cycle();
        chk("t2_pend_fall", bus.swap_pending, 0);
        chk("t2_lenB", bus.active_len, 2);
        idle(3);
        bus.step = 0;
        idle(3);
        want = '{32'd1, 32'd2, 32'd3, 32'd7, 32'd8, 32'd7};
        chk_seen("t2_seq");
        // write and commit in the same cycle
        wr(32'h53); wr(32'h54);
        bus.writeEn = 1; bus.phase = 32'h55; bus.commit = 1;
        cycle();
        bus.writeEn = 0; bus.commit = 0;
        bus.play_en = 0; idle(3);
        chk("t3_len", bus.active_len, 3);
        bus.play_en = 1; idle(2);
        steps(3); idle(3);
        want = '{32'h53, 32'h54, 32'h55};
        chk_seen("t3_seq");
        // overflow and writes while pending
        for (int i = 0; i < 4; i++) wr(32'hA0 + i);
        chk("t4_drop0", bus.wr_drop, 0);
        wr(32'hA4);
        chk("t4_drop1", bus.wr_drop, 1);
        bus.commit = 1; cycle(); bus.commit = 0;
        chk("t4_pending", bus.swap_pending, 1);
        wr(32'hEE); wr(32'hEF);
        steps(7); idle(3);
        chk("t4_len", bus.active_len, 4);
        want = '{32'h53, 32'h54, 32'h55, 32'hA0, 32'hA1, 32'hA2, 32'hA3};
        chk_seen("t4_seq");
        // empty commit, disabled steps, restart on play_en toggle
        bus.commit = 1; cycle(); bus.commit = 0;
        chk("t5_empty_commit", bus.swap_pending, 0);
        bus.play_en = 0; idle(2);
        steps(3); idle(3);
        want.delete();
        chk_seen("t5_noplay");
        bus.play_en = 1; idle(2);
        steps(2);
        bus.play_en = 0; idle(2);
        bus.play_en = 1; idle(2);
        steps(1); idle(3);
        want = '{32'hA0, 32'hA1, 32'hA0};
        chk_seen("t5_restart");
        // reset mid-play
        steps(1);
        reset = 1; cycle(); reset = 0;
        chk("t6_len", bus.active_len, 0);
        chk("t6_valid", bus.phase_valid, 0);
        chk("t6_out", bus.phase_out, 0);
        chk("t6_pending", bus.swap_pending, 0);
        steps(3); idle(3);
        want.delete();
        chk_seen("t6_noplay");
        // random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            bus.writeEn = $urandom_range(0, 9) < 4;
            bus.phase = $urandom;
            bus.commit = $urandom_range(0, 19) == 0;
            bus.step = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 29) == 0) bus.play_en = !bus.play_en;
            reset = $urandom_range(0, 299) == 0;
            cycle();
        end
        reset = 0; bus.writeEn = 0; bus.commit = 0; bus.step = 0;
        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
